program_loader: RTL



---
 rtl/program_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Loads a framed byte stream (SYNC, LEN, LEN x {hi,lo}, CSUM) into the CPU's
// 256 x 16-bit instruction memory, holding the CPU while the image is loading or bad.
module program_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;

    logic [2:0] state;
    logic [7:0] sum;
    logic [7:0] sum_next;
    logic [7:0] hi_byte;
    logic [8:0] count;
    logic       take;

    // The write cycle owns the memory port, so no byte is consumed during it.
    assign rx_ready = (state != S_WRITE);
    assign take     = rx_valid && rx_ready;
    assign sum_next = sum + rx_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= 8'h00;
            imem_wdata <= 16'h0000;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            sum        <= 8'h00;
            count      <= 9'd0;
        end else begin
            load_done <= 1'b0;
            imem_we   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take && rx_data == SYNC_BYTE) begin
                        state      <= S_LEN;
                        cpu_hold   <= 1'b1;
                        load_error <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (take) begin
                        // LEN of zero encodes a full 256-word image.
                        count     <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        sum       <= rx_data;
                        imem_addr <= 8'h00;
                        state     <= S_HI;
                    end
                end
                S_HI: begin
                    if (take) begin
                        sum   <= sum_next;
                        state <= S_LO;
                    end
                end
                S_LO: begin
                    if (take) begin
                        sum        <= sum_next;
                        imem_wdata <= {hi_byte, rx_data};
                        imem_we    <= 1'b1;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    imem_addr <= imem_addr + 8'd1;
                    count     <= count - 9'd1;
                    state     <= (count == 9'd1) ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    if (take) begin
                        state <= S_IDLE;
                        if (sum_next == 8'h00) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            load_error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // High byte staging register; only ever read after being loaded in S_HI.
    always_ff @(posedge clk) begin
        if (state == S_HI && take) begin
            hi_byte <= rx_data;
        end
    end

endmodule
